// File: rtl/frame_dump_ctrl.sv
// Frame dump controller: waits for the start of a fresh frame, forwards a
// fixed number of whole frames to an image sink and checks each frame's
// geometry against SIZE_X x SIZE_Y.
// Optional feature: define FRAME_DUMP_CTRL_ABORT_EN to add an abort input
// that closes the current job early.
module frame_dump_ctrl #(
  parameter int SIZE_X = 64,
  parameter int SIZE_Y = 64,
  parameter int LEN_X  = $clog2(SIZE_X) + 1,
  parameter int LEN_Y  = $clog2(SIZE_Y) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  num_frames,
  input  logic [23:0] pixel_in,
  input  logic        de_in,
  input  logic        vsync_in,
`ifdef FRAME_DUMP_CTRL_ABORT_EN
  input  logic        abort,
`endif
  output logic [23:0] pixel_out,
  output logic        de_out,
  output logic        vsync_out,
  output logic        busy,
  output logic        done,
  output logic        size_err,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_CAPTURE,
    S_DONE
  } state_e;

  localparam logic [LEN_X-1:0] X_LAST = LEN_X'(SIZE_X - 1);
  localparam logic [LEN_Y-1:0] Y_END  = LEN_Y'(SIZE_Y);

  state_e            state_q, state_d;
  logic              vsync_q;
  logic [LEN_X-1:0]  hcnt_q, hcnt_d;
  logic [LEN_Y-1:0]  vcnt_q, vcnt_d;
  logic [7:0]        num_q, num_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              size_err_q, size_err_d;
  logic [23:0]       pixel_out_q, pixel_out_d;
  logic              de_out_q, de_out_d;
  logic              vsync_out_q, vsync_out_d;
  logic              done_q, done_d;

  logic abort_w;
  logic vs_rise, vs_fall;
  logic pix_ok, pix_ovf;

`ifdef FRAME_DUMP_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Edges are judged against the previous cycle's vsync so that a frame
  // already running when the job starts is never mistaken for a new one.
  assign vs_rise = vsync_in & ~vsync_q;
  assign vs_fall = ~vsync_in & vsync_q;

  // Pixels arriving once all lines are full are overflow and are dropped.
  assign pix_ok  = de_in & (vcnt_q != Y_END);
  assign pix_ovf = de_in & (vcnt_q == Y_END);

  // Next-state, counter and output logic for the dump sequencer.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    num_d       = num_q;
    frame_cnt_d = frame_cnt_q;
    size_err_d  = size_err_q;
    pixel_out_d = pixel_out_q;
    de_out_d    = 1'b0;
    vsync_out_d = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d       = num_frames;
          frame_cnt_d = 8'd0;
          size_err_d  = 1'b0;
          state_d     = (num_frames == 8'd0) ? S_DONE : S_WAIT_SOF;
        end
      end

      S_WAIT_SOF: begin
        if (abort_w) begin
          vsync_out_d = 1'b1;
          state_d     = S_DONE;
        end else if (vs_fall) begin
          hcnt_d  = '0;
          vcnt_d  = '0;
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        pixel_out_d = pixel_in;
        de_out_d    = pix_ok;
        if (pix_ovf) size_err_d = 1'b1;
        if (pix_ok) begin
          if (hcnt_q == X_LAST) begin
            hcnt_d = '0;
            vcnt_d = vcnt_q + 1'b1;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        // The geometry check uses the counts including this cycle's pixel.
        if (abort_w) begin
          vsync_out_d = 1'b1;
          state_d     = S_DONE;
        end else if (vs_rise) begin
          vsync_out_d = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (!((vcnt_d == Y_END) && (hcnt_d == '0))) size_err_d = 1'b1;
          state_d = (frame_cnt_q + 8'd1 == num_q) ? S_DONE : S_WAIT_SOF;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset clears everything, including vsync history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vsync_q     <= 1'b0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      num_q       <= 8'd0;
      frame_cnt_q <= 8'd0;
      size_err_q  <= 1'b0;
      pixel_out_q <= 24'd0;
      de_out_q    <= 1'b0;
      vsync_out_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      vsync_q     <= vsync_in;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      num_q       <= num_d;
      frame_cnt_q <= frame_cnt_d;
      size_err_q  <= size_err_d;
      pixel_out_q <= pixel_out_d;
      de_out_q    <= de_out_d;
      vsync_out_q <= vsync_out_d;
      done_q      <= done_d;
    end
  end

  assign pixel_out = pixel_out_q;
  assign de_out    = de_out_q;
  assign vsync_out = vsync_out_q;
  assign done      = done_q;
  assign size_err  = size_err_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Self-checking bench for frame_dump_ctrl with a 4x2 frame geometry.
// Job-level scenarios are table driven; reset, zero-frame and abort corner
// cases are hand-written sequences.
module tb_frame_dump_ctrl;

  localparam int SX = 4;
  localparam int SY = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_frames = 8'd0;
  logic [23:0] pixel_in = 24'd0;
  logic        de_in = 1'b0;
  logic        vsync_in = 1'b1;
`ifdef FRAME_DUMP_CTRL_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic [23:0] pixel_out;
  logic        de_out, vsync_out, busy, done, size_err;
  logic [7:0]  frame_cnt;

  frame_dump_ctrl #(.SIZE_X(SX), .SIZE_Y(SY)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_frames(num_frames),
    .pixel_in(pixel_in), .de_in(de_in), .vsync_in(vsync_in),
`ifdef FRAME_DUMP_CTRL_ABORT_EN
    .abort(abort),
`endif
    .pixel_out(pixel_out), .de_out(de_out), .vsync_out(vsync_out),
    .busy(busy), .done(done), .size_err(size_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycle counter and output monitor, sampled on the falling edge.
  int cyc_n = 0;
  logic [23:0] pix_d = 24'd0;
  int de_tot = 0, vs_tot = 0, done_tot = 0, pix_bad = 0, vs_cyc = 0, done_cyc = 0;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    pix_d <= pixel_in;
  end

  always @(negedge clk) begin
    if (de_out) begin
      de_tot++;
      if (pixel_out !== pix_d) pix_bad++;
    end
    if (vsync_out) begin
      vs_tot++;
      vs_cyc = cyc_n;
    end
    if (done) begin
      done_tot++;
      done_cyc = cyc_n;
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  int pix_idx  = 0;
  int rise_cyc = 0;

  task automatic cyc(input logic de, input logic vs);
    de_in    = de;
    vsync_in = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic pix();
    pix_idx++;
    pixel_in = 24'h100000 + 24'(pix_idx);
    cyc(1'b1, 1'b0);
  endtask

  // One frame: vsync falls, npix pixels with a blank after each line, vsync rises.
  task automatic drive_frame(input int npix);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < npix; i++) begin
      pix();
      if (((i + 1) % SX == 0) || (i == npix - 1)) cyc(1'b0, 1'b0);
    end
    rise_cyc = cyc_n;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 50) begin
      cyc(1'b0, 1'b1);
      k++;
    end
    check({name, " idle"}, busy, 0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
  endtask

  typedef struct {
    logic       mid;
    logic [7:0] num;
    int         npix;
    int         nfr;
    int         exp_de;
    int         exp_vs;
    logic [7:0] exp_fc;
    logic       exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int de0, vs0, dn0, pb0;
    string nm;

    // Geometry is 4x2, so a clean frame is 8 pixels.
    vecs[0] = '{mid: 1'b1, num: 8'd1, npix: 8, nfr: 1, exp_de: 8,  exp_vs: 1, exp_fc: 8'd1, exp_err: 1'b0};
    vecs[1] = '{mid: 1'b0, num: 8'd3, npix: 8, nfr: 3, exp_de: 24, exp_vs: 3, exp_fc: 8'd3, exp_err: 1'b0};
    vecs[2] = '{mid: 1'b0, num: 8'd1, npix: 7, nfr: 1, exp_de: 7,  exp_vs: 1, exp_fc: 8'd1, exp_err: 1'b1};
    vecs[3] = '{mid: 1'b0, num: 8'd2, npix: 8, nfr: 2, exp_de: 16, exp_vs: 2, exp_fc: 8'd2, exp_err: 1'b0};
    vecs[4] = '{mid: 1'b0, num: 8'd1, npix: 9, nfr: 1, exp_de: 8,  exp_vs: 1, exp_fc: 8'd1, exp_err: 1'b1};

    // Reset state.
    #12;
    check("rst busy", busy, 0);
    check("rst de_out", de_out, 0);
    check("rst vsync_out", vsync_out, 0);
    check("rst done", done, 0);
    check("rst frame_cnt", frame_cnt, 0);
    check("rst size_err", size_err, 0);
    check("rst pixel_out", pixel_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);

    // Table-driven jobs.
    foreach (vecs[i]) begin
      de0 = de_tot; vs0 = vs_tot; dn0 = done_tot; pb0 = pix_bad;
      nm = $sformatf("v%0d", i);
      if (vecs[i].mid) begin
        // Source frame already running when start arrives: must be skipped.
        cyc(1'b0, 1'b0);
        pix();
        pix();
        start = 1'b1; num_frames = vecs[i].num;
        pix();
        start = 1'b0;
        pix();
        pix();
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
      end else begin
        start = 1'b1; num_frames = vecs[i].num;
        cyc(1'b0, 1'b1);
        start = 1'b0;
      end
      for (int f = 0; f < vecs[i].nfr; f++) drive_frame(vecs[i].npix);
      wait_idle(nm);
      check({nm, " de_out count"}, de_tot - de0, vecs[i].exp_de);
      check({nm, " vsync_out count"}, vs_tot - vs0, vecs[i].exp_vs);
      check({nm, " done count"}, done_tot - dn0, 1);
      check({nm, " frame_cnt"}, frame_cnt, vecs[i].exp_fc);
      check({nm, " size_err"}, size_err, vecs[i].exp_err);
      check({nm, " pixel delay"}, pix_bad - pb0, 0);
      check({nm, " vsync_out align"}, vs_cyc, rise_cyc + 1);
      check({nm, " done after vsync"}, done_cyc, vs_cyc + 1);
      check({nm, " pixel_out hold"}, pixel_out, 24'h100000 + 24'(pix_idx));
    end

    // Zero-frame job; a second start while busy is ignored.
    de0 = de_tot; vs0 = vs_tot;
    start = 1'b1; num_frames = 8'd0;
    cyc(1'b0, 1'b1);
    check("zero busy", busy, 1);
    check("zero done early", done, 0);
    num_frames = 8'd5;
    cyc(1'b0, 1'b1);
    start = 1'b0;
    check("zero done", done, 1);
    check("zero busy after", busy, 0);
    cyc(1'b0, 1'b1);
    check("zero done single", done, 0);
    check("zero restart ignored", busy, 0);
    check("zero frame_cnt", frame_cnt, 0);
    check("zero de_out count", de_tot - de0, 0);
    check("zero vsync_out count", vs_tot - vs0, 0);

    // Reset in the middle of a captured frame.
    start = 1'b1; num_frames = 8'd1;
    cyc(1'b0, 1'b1);
    start = 1'b0;
    cyc(1'b0, 1'b0);
    pix();
    pix();
    pix();
    check("pre-reset de_out", de_out, 1);
    check("pre-reset busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst de_out", de_out, 0);
    check("mid rst pixel_out", pixel_out, 0);
    check("mid rst busy", busy, 0);
    check("mid rst vsync_out", vsync_out, 0);
    check("mid rst frame_cnt", frame_cnt, 0);
    check("mid rst size_err", size_err, 0);
    check("mid rst done", done, 0);
    vs0 = vs_tot;
    cyc(1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    check("mid rst no vsync_out", vs_tot - vs0, 0);
    check("mid rst stays idle", busy, 0);

`ifdef FRAME_DUMP_CTRL_ABORT_EN
    // Abort a partial second frame of a three-frame job.
    vs0 = vs_tot; dn0 = done_tot;
    start = 1'b1; num_frames = 8'd3;
    cyc(1'b0, 1'b1);
    start = 1'b0;
    drive_frame(8);
    check("abort frame_cnt before", frame_cnt, 1);
    cyc(1'b0, 1'b0);
    pix();
    pix();
    pix();
    abort = 1'b1;
    cyc(1'b0, 1'b0);
    abort = 1'b0;
    check("abort vsync_out", vsync_out, 1);
    check("abort busy", busy, 1);
    cyc(1'b0, 1'b0);
    check("abort done", done, 1);
    check("abort vsync_out single", vsync_out, 0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    check("abort vsync_out count", vs_tot - vs0, 2);
    check("abort done count", done_tot - dn0, 1);
    check("abort frame_cnt", frame_cnt, 1);
    check("abort idle", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_dump_ctrl.md
FRAME_DUMP_CTRL -- requirements
Module: frame_dump_ctrl

Interface
REQ-001 SHALL have parameter SIZE_X, default 64: active pixels per line.
REQ-002 SHALL have parameter SIZE_Y, default 64: active lines per frame.
REQ-003 SHALL have parameter LEN_X, default $clog2(SIZE_X)+1: column counter width.
REQ-004 SHALL have parameter LEN_Y, default $clog2(SIZE_Y)+1: line counter width.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset; asynchronous, active-low.
REQ-007 SHALL have port start, input, 1: one-cycle request to dump frames.
REQ-008 SHALL have port num_frames, input, 8: frame count, sampled on an accepted start.
REQ-009 SHALL have port pixel_in, input, 24: source pixel, {B,G,R}.
REQ-010 SHALL have port de_in, input, 1: source data enable.
REQ-011 SHALL have port vsync_in, input, 1: source vsync, high during vertical blanking.
REQ-012 SHALL have port pixel_out, output, 24: pixel to the image sink.
REQ-013 SHALL have port de_out, output, 1: sink data enable.
REQ-014 SHALL have port vsync_out, output, 1: one-cycle end-of-frame pulse to the sink.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-017 SHALL have port size_err, output, 1: sticky frame-geometry error.
REQ-018 SHALL have port frame_cnt, output, 8: frames completed in the current job.

Function
REQ-019 SHALL implement the states IDLE, WAIT_SOF, CAPTURE and DONE.
REQ-020 IDLE: start=1 SHALL latch num_frames, clear frame_cnt and size_err, and go to WAIT_SOF; if num_frames=0, it SHALL go to DONE instead.
REQ-021 start SHALL be ignored in every state except IDLE.
REQ-022 WAIT_SOF SHALL advance to CAPTURE on a falling edge of vsync_in, detected against a registered copy of vsync_in; a frame already in progress SHALL never be captured.
REQ-023 On entry to CAPTURE, the column counter HCnt and line counter VCnt SHALL be zero.
REQ-024 In CAPTURE with de_in=1: HCnt SHALL increment; at HCnt=SIZE_X-1 it SHALL wrap to 0 and VCnt SHALL increment.
REQ-025 In CAPTURE, pixel_out and de_out SHALL equal pixel_in and de_in delayed by exactly one cycle.
REQ-026 Outside CAPTURE, de_out SHALL be 0 and pixel_out SHALL hold its last value.
REQ-027 Overflow: de_in=1 while VCnt=SIZE_Y SHALL set size_err and force de_out=0 for that pixel.
REQ-028 On a rising edge of vsync_in in CAPTURE: vsync_out SHALL be 1 for exactly one cycle, aligned one cycle after that edge.
REQ-029 On the same edge, frame_cnt SHALL increment.
REQ-030 On the same edge, size_err SHALL be set unless VCnt=SIZE_Y and HCnt=0 (underflow or partial line).
REQ-031 After that edge, the block SHALL go to DONE if frame_cnt+1 equals the latched count, otherwise to WAIT_SOF.
REQ-032 A de_in pixel in the same cycle as the vsync_in rising edge SHALL be forwarded and counted before the size check.
REQ-033 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-034 frame_cnt and size_err SHALL hold their values until the next accepted start.
REQ-035 frame_cnt arithmetic SHALL be 8-bit; the maximum job is 255 frames, so no wrap occurs.

Reset
REQ-036 rst_n=0 SHALL immediately force state IDLE and set every output, counter and the vsync history register to 0.
REQ-037 Reset mid-CAPTURE SHALL abandon the frame with no vsync_out pulse.

Configuration
REQ-038 With macro FRAME_DUMP_CTRL_ABORT_EN defined, the block SHALL add port abort, input, 1.
REQ-039 With FRAME_DUMP_CTRL_ABORT_EN defined, abort=1 in WAIT_SOF or CAPTURE SHALL emit one vsync_out pulse and go to DONE, with frame_cnt unchanged; in CAPTURE the pulse closes the partial frame.
REQ-040 With FRAME_DUMP_CTRL_ABORT_EN undefined, the abort port SHALL be absent and a job SHALL run only to completion or reset.

Verification
REQ-041 Bench SHALL use SIZE_X=4, SIZE_Y=2, num_frames=1, start while mid-frame -> the first partial frame is skipped; the next frame gives 8 de_out pulses, one vsync_out, frame_cnt=1, done pulse, size_err=0.
REQ-042 Bench SHALL drive num_frames=3 over three clean frames -> 3 vsync_out pulses, frame_cnt=3, done 1 cycle after the third vsync_out.
REQ-043 Bench SHALL drive a frame of 7 pixels -> size_err=1 at the vsync edge and the job still completes.
REQ-044 Bench SHALL drive a frame of 9 pixels -> the 9th pixel is not forwarded and size_err=1.
REQ-045 Bench SHALL drive num_frames=0 -> done the cycle after IDLE exits, with no de_out; a second start while busy is ignored.
REQ-046 Bench SHALL assert rst_n low mid-CAPTURE, then separately assert abort with the macro defined -> all outputs 0 with no vsync_out; abort gives one vsync_out then done with frame_cnt unchanged.
